// File: rtl/daq_frame_packer.sv
// Buffers 6-channel ADC sample sets in a frame FIFO and emits them as header-tagged 32-bit AXI4-Stream packets.
// Define PACKER_TIMESTAMP_EN to add a 32-bit cycle-count timestamp word after the header.
module daq_frame_packer #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] HDR_MAGIC  = 16'hDA3C
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [15:0]                   data_ch0,
  input  logic [15:0]                   data_ch1,
  input  logic [15:0]                   data_ch2,
  input  logic [15:0]                   data_ch3,
  input  logic [15:0]                   data_ch4,
  input  logic [15:0]                   data_ch5,
  input  logic                          data_valid,
  output logic [31:0]                   m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [15:0]                   drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
`ifdef PACKER_TIMESTAMP_EN
  localparam int EW = 144;
`else
  localparam int EW = 112;
`endif

  localparam logic [2:0] S_HDR = 3'd0;
`ifdef PACKER_TIMESTAMP_EN
  localparam logic [2:0] S_TS  = 3'd1;
`endif
  localparam logic [2:0] S_D01 = 3'd2;
  localparam logic [2:0] S_D23 = 3'd3;
  localparam logic [2:0] S_D45 = 3'd4;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] head;
  logic [EW-1:0] wr_entry;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [15:0]   seq;
  logic          capture;
  logic          full;
  logic          xfer;
  logic          pop;
  logic          push;

`ifdef PACKER_TIMESTAMP_EN
  logic [31:0]   ts_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + 32'd1;
  end

  assign wr_entry = {ts_cnt, seq, data_ch0, data_ch1, data_ch2, data_ch3, data_ch4, data_ch5};
`else
  assign wr_entry = {seq, data_ch0, data_ch1, data_ch2, data_ch3, data_ch4, data_ch5};
`endif

  assign capture       = data_valid && enable;
  assign full          = (fifo_level == LW'(FIFO_DEPTH));
  assign m_axis_tvalid = (fifo_level != '0);
  assign xfer          = m_axis_tvalid && m_axis_tready;
  assign pop           = xfer && (state == S_D45);
  // A full FIFO still accepts a frame when the head frame leaves in the same cycle.
  assign push          = capture && (!full || pop);
  assign head          = mem[rd_ptr];

  always_comb begin
    state_nxt = state;
    case (state)
`ifdef PACKER_TIMESTAMP_EN
      S_HDR:   state_nxt = S_TS;
      S_TS:    state_nxt = S_D01;
`else
      S_HDR:   state_nxt = S_D01;
`endif
      S_D01:   state_nxt = S_D23;
      S_D23:   state_nxt = S_D45;
      default: state_nxt = S_HDR;
    endcase
  end

  always_comb begin
    m_axis_tdata = '0;
    m_axis_tlast = 1'b0;
    if (m_axis_tvalid) begin
      case (state)
        S_HDR:   m_axis_tdata = {HDR_MAGIC, head[111:96]};
`ifdef PACKER_TIMESTAMP_EN
        S_TS:    m_axis_tdata = head[143:112];
`endif
        S_D01:   m_axis_tdata = head[95:64];
        S_D23:   m_axis_tdata = head[63:32];
        S_D45: begin
          m_axis_tdata = head[31:0];
          m_axis_tlast = 1'b1;
        end
        default: m_axis_tdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      state      <= S_HDR;
      seq        <= '0;
      drop_cnt   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      if (xfer) state <= state_nxt;
      // Dropped frames still consume a sequence number so the gap is visible.
      if (capture) seq <= seq + 16'd1;
      if (capture && !push && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_daq_frame_packer.sv
// Randomized and directed bench for daq_frame_packer against a word-queue reference model.
module tb_daq_frame_packer;

  localparam int DEPTH = 8;
`ifdef PACKER_TIMESTAMP_EN
  localparam int NW = 5;
`else
  localparam int NW = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] ch [6];
  logic        data_valid;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [15:0] drop_cnt;
  logic [$clog2(DEPTH):0] fifo_level;

  always #5 clk = ~clk;

  daq_frame_packer #(.FIFO_DEPTH(DEPTH), .HDR_MAGIC(16'hDA3C)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .data_ch0(ch[0]), .data_ch1(ch[1]), .data_ch2(ch[2]),
    .data_ch3(ch[3]), .data_ch4(ch[4]), .data_ch5(ch[5]),
    .data_valid(data_valid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .drop_cnt(drop_cnt), .fifo_level(fifo_level)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: every pending output word, frames stored contiguously.
  logic [31:0] wq [$];
  logic [31:0] obs_q [$];
  logic [15:0] m_seq = 16'd0;
  int          m_drop = 0;
  logic [31:0] m_cyc = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int m_level();
    return (wq.size() + NW - 1) / NW;
  endfunction

  task automatic rand_ch();
    for (int i = 0; i < 6; i++) ch[i] = 16'($urandom);
  endtask

  task automatic step(input logic dv, input logic en, input logic rdy, input logic rst);
    logic exp_vld;
    logic last_hs;
    int   lvl;
    data_valid    = dv;
    enable        = en;
    m_axis_tready = rdy;
    rst_n         = ~rst;
    @(negedge clk);
    exp_vld = (wq.size() != 0);
    chk("tvalid", 32'(m_axis_tvalid), 32'(exp_vld));
    if (exp_vld) begin
      chk("tdata", m_axis_tdata, wq[0]);
      chk("tlast", 32'(m_axis_tlast), 32'(wq.size() % NW == 1));
    end
    chk("fifo_level", 32'(fifo_level), 32'(m_level()));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    if (rst) begin
      wq.delete();
      m_seq  = 16'd0;
      m_drop = 0;
      m_cyc  = 32'd0;
    end else begin
      lvl     = m_level();
      last_hs = exp_vld && rdy && (wq.size() % NW == 1);
      if (exp_vld && rdy) begin
        obs_q.push_back(m_axis_tdata);
        void'(wq.pop_front());
      end
      if (dv && en) begin
        if (lvl < DEPTH || last_hs) begin
          wq.push_back({16'hDA3C, m_seq});
`ifdef PACKER_TIMESTAMP_EN
          wq.push_back(m_cyc);
`endif
          wq.push_back({ch[0], ch[1]});
          wq.push_back({ch[2], ch[3]});
          wq.push_back({ch[4], ch[5]});
        end else if (m_drop < 65535) begin
          m_drop++;
        end
        m_seq = m_seq + 16'd1;
      end
      m_cyc = m_cyc + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && wq.size() != 0; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("drain_idle", 32'(m_axis_tvalid), 32'd0);
  endtask

  logic [31:0] exp1 [NW];
  logic [31:0] ts_rec;

  initial begin
    rst_n = 1'b0; enable = 1'b0; data_valid = 1'b0; m_axis_tready = 1'b0;
    for (int i = 0; i < 6; i++) ch[i] = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_tdata", m_axis_tdata, 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);

    // single frame with known channel values
    for (int i = 0; i < 6; i++) ch[i] = 16'h1111 * 16'(i + 1);
    obs_q.delete();
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t1_tvalid_rise", 32'(m_axis_tvalid), 32'd1);
    drain();
    exp1[0] = 32'hDA3C0000;
    exp1[NW-3] = 32'h11112222;
    exp1[NW-2] = 32'h33334444;
    exp1[NW-1] = 32'h55556666;
    chk("t1_words", 32'(obs_q.size()), 32'(NW));
    for (int i = 0; i < NW; i++)
      if (i == 0 || i >= NW - 3) chk("t1_word", (i < obs_q.size()) ? obs_q[i] : 32'hX, exp1[i]);

    // tready toggling during a packet
    rand_ch();
    obs_q.delete();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    exp1[0] = {ch[0], ch[1]};
    for (int i = 0; i < 2 * NW + 2; i++) step(1'b0, 1'b1, 1'(i % 2), 1'b0);
    chk("t2_words", 32'(obs_q.size()), 32'(NW));
    chk("t2_d01", (obs_q.size() > NW - 3) ? obs_q[NW-3] : 32'hX, exp1[0]);
    chk("t2_hdr", (obs_q.size() > 0) ? obs_q[0] : 32'hX, 32'hDA3C0001);

    // stall with overflow, then full-with-pop capture
    step(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin rand_ch(); step(1'b1, 1'b1, 1'b0, 1'b0); end
    chk("t3_level_full", 32'(fifo_level), 32'(DEPTH));
    chk("t3_drop", 32'(drop_cnt), 32'd2);
    obs_q.delete();
    for (int i = 0; i < NW - 1; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    rand_ch();
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t4_level", 32'(fifo_level), 32'(DEPTH));
    chk("t4_drop", 32'(drop_cnt), 32'd2);
    drain();
    chk("t3_words", 32'(obs_q.size()), 32'(9 * NW));
    for (int f = 0; f < 9; f++)
      chk("t3_hdr", (f * NW < obs_q.size()) ? obs_q[f*NW] : 32'hX,
          {16'hDA3C, (f < 8) ? 16'(f) : 16'd10});

    // reset during D23
    rand_ch();
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < NW - 2; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("t6_pre_drop", 32'(drop_cnt), 32'd2);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    chk("t6_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("t6_level", 32'(fifo_level), 32'd0);
    chk("t6_drop", 32'(drop_cnt), 32'd0);
    obs_q.delete();
    rand_ch();
    step(1'b1, 1'b1, 1'b1, 1'b0);
    drain();
    chk("t6_seq0", (obs_q.size() > 0) ? obs_q[0] : 32'hX, 32'hDA3C0000);

    // enable gating, then sequence wrap
    step(1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin rand_ch(); step(1'b1, 1'b0, 1'b1, 1'b0); end
    obs_q.delete();
    rand_ch();
    step(1'b1, 1'b1, 1'b1, 1'b0);
    drain();
    chk("t5_seq0", (obs_q.size() > 0) ? obs_q[0] : 32'hX, 32'hDA3C0000);
    for (int i = 0; i < 65535; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    drain();
    obs_q.delete();
    rand_ch();
    step(1'b1, 1'b1, 1'b1, 1'b0);
    drain();
    chk("t5_wrap", (obs_q.size() > 0) ? obs_q[0] : 32'hX, 32'hDA3C0000);

`ifdef PACKER_TIMESTAMP_EN
    obs_q.delete();
    rand_ch();
    ts_rec = m_cyc;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    drain();
    chk("ts_word", (obs_q.size() > 1) ? obs_q[1] : 32'hX, ts_rec);
    chk("ts_words", 32'(obs_q.size()), 32'd5);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rand_ch();
      step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) != 0),
           1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 499) == 0));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
